// File: rtl/seg7_totient_checker.sv
// Seven-segment receive monitor: decodes {A..G} and tracks the totient sequence phi(1..16); outputs register
// one clk_0 edge after sample_en, with no backpressure. Define SEG7_CHK_STICKY_EN to build the sticky fail flag.
module seg7_totient_checker #(
  parameter int CNT_W          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             clk_0,
  input  logic             R,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             E,
  input  logic             F,
  input  logic             G,
  input  logic             sample_en,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             bad_pattern,
  output logic             locked,
  output logic             mismatch,
  output logic             seq_done,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] seq_count,
  output logic             fail
);

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] SEEN1 = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0] state;
  logic [3:0] idx;
  logic [6:0] seg_raw;
  logic [6:0] seg;
  logic [3:0] dec_digit;
  logic       dec_ok;
  logic [3:0] exp_digit;
  logic       hit;

  assign seg_raw = {A, B, C, D, E, F, G};
  assign seg     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

  always_comb begin
    dec_ok    = 1'b1;
    dec_digit = 4'h0;
    case (seg)
      7'b1111110: dec_digit = 4'h0;
      7'b0110000: dec_digit = 4'h1;
      7'b1101101: dec_digit = 4'h2;
      7'b1111001: dec_digit = 4'h3;
      7'b0110011: dec_digit = 4'h4;
      7'b1011011: dec_digit = 4'h5;
      7'b1011111: dec_digit = 4'h6;
      7'b1110000: dec_digit = 4'h7;
      7'b1111111: dec_digit = 4'h8;
      7'b1111011: dec_digit = 4'h9;
      7'b1110111: dec_digit = 4'hA;
      7'b0011111: dec_digit = 4'hB;
      7'b1001110: dec_digit = 4'hC;
      7'b0111101: dec_digit = 4'hD;
      7'b1001111: dec_digit = 4'hE;
      7'b1000111: dec_digit = 4'hF;
      default:    dec_ok    = 1'b0;
    endcase
  end

  // phi(idx+1) for idx 0..15
  always_comb begin
    exp_digit = 4'h1;
    case (idx)
      4'd0:  exp_digit = 4'h1;
      4'd1:  exp_digit = 4'h1;
      4'd2:  exp_digit = 4'h2;
      4'd3:  exp_digit = 4'h2;
      4'd4:  exp_digit = 4'h4;
      4'd5:  exp_digit = 4'h2;
      4'd6:  exp_digit = 4'h6;
      4'd7:  exp_digit = 4'h4;
      4'd8:  exp_digit = 4'h6;
      4'd9:  exp_digit = 4'h4;
      4'd10: exp_digit = 4'hA;
      4'd11: exp_digit = 4'h4;
      4'd12: exp_digit = 4'hC;
      4'd13: exp_digit = 4'h6;
      4'd14: exp_digit = 4'h8;
      4'd15: exp_digit = 4'h8;
      default: exp_digit = 4'h1;
    endcase
  end

  assign hit    = dec_ok && (dec_digit == exp_digit);
  assign locked = (state == TRACK);

  always_ff @(posedge clk_0) begin
    if (R) begin
      state       <= HUNT;
      idx         <= 4'd0;
      digit       <= 4'h0;
      digit_valid <= 1'b0;
      bad_pattern <= 1'b0;
      mismatch    <= 1'b0;
      seq_done    <= 1'b0;
      err_count   <= '0;
      seq_count   <= '0;
    end else begin
      bad_pattern <= 1'b0;
      mismatch    <= 1'b0;
      seq_done    <= 1'b0;
      if (sample_en) begin
        digit       <= dec_digit;
        digit_valid <= dec_ok;
        bad_pattern <= !dec_ok;
        case (state)
          HUNT: begin
            if (dec_ok && dec_digit == 4'h1) state <= SEEN1;
          end
          SEEN1: begin
            // The generator holds 1 while in reset, so repeated 1s keep us waiting here.
            if (dec_ok && dec_digit == 4'h1) begin
              state <= SEEN1;
            end else if (dec_ok && dec_digit == 4'h2) begin
              state <= TRACK;
              idx   <= 4'd3;
            end else begin
              state <= HUNT;
            end
          end
          TRACK: begin
            if (hit) begin
              idx <= idx + 4'd1;
              if (idx == 4'd15) begin
                seq_done <= 1'b1;
                if (seq_count != CNT_MAX) seq_count <= seq_count + CNT_ONE;
              end
            end else begin
              mismatch <= 1'b1;
              if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
              state <= HUNT;
              idx   <= 4'd0;
            end
          end
          default: begin
            state <= HUNT;
            idx   <= 4'd0;
          end
        endcase
      end
    end
  end

`ifdef SEG7_CHK_STICKY_EN
  logic track_err;
  assign track_err = sample_en && (state == TRACK) && !hit;

  always_ff @(posedge clk_0) begin
    if (R) begin
      fail <= 1'b0;
    end else if (track_err) begin
      fail <= 1'b1;
    end
  end
`else
  assign fail = 1'b0;
`endif

endmodule
